// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle RV32I core. The opcode is decoded once per
//   instruction. The FSM then steps through fetch, decode, execute, memory and
//   writeback, and drives the datapath enables and mux selects for each step.
//
//   Parameter ILLEGAL_HALT (default 0):
//     1 = an unsupported opcode parks the FSM in HALT until reset.
//     0 = an unsupported opcode is skipped and the FSM returns to FETCH.
//
//   Optional macro MC_MEM_WAIT_EN:
//     Defined   = FETCH, MEMREAD and MEMWRITE hold until mem_ready is 1.
//     Undefined = mem_ready is ignored and every state lasts one cycle.
//
//   Memory handshake: the controller presents the request for the whole
//   dwell of FETCH, MEMREAD or MEMWRITE. mem_ready = 1 means the access
//   completes on this clock edge. There is no separate request strobe.
//
//   Ports
//     clk, reset     rising-edge clock, synchronous active-high reset
//     op             opcode field of the instruction register
//     zero           ALU zero flag, used in the same cycle by BEQ
//     mem_ready      memory access completes this cycle
//     pc_write .. reg_write   datapath enables and mux selects
//     illegal_op     sticky flag: an unsupported opcode was decoded
//     state_dbg      current state encoding
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_BEQ = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // Registered Moore control word. 'branch' marks BEQ, where pc_write
  // follows zero combinationally. 'fetch' marks FETCH, where the IR and PC
  // enables may be gated by mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       branch;
    logic       fetch;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   mem_go;
  logic   fetch_gate;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.pc_write = 1'b1; c.fetch = 1'b1;
        c.alu_src_b = 2'b10; c.result_src = 2'b10;
      end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_legal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) ||
           (o == OP_I) || (o == OP_BEQ) || (o == OP_JAL);
  endfunction

`ifdef MC_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_go) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_go) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_go) state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // The control word is loaded together with the state it belongs to, so
  // the outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      ctrl_q     <= ctrl_for(S_FETCH);
      illegal_op <= 1'b0;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_for(state_next);
      if (state == S_DECODE && !op_legal(op)) illegal_op <= 1'b1;
    end
  end

  // Outside FETCH the gate is open. In FETCH the IR and PC only load when
  // the instruction word has arrived.
  assign fetch_gate = ctrl_q.fetch ? mem_go : 1'b1;

  // Reset kills every state-changing strobe at once. This also covers the
  // cycle in which an instruction is aborted.
  assign pc_write   = ~reset & ((ctrl_q.pc_write & fetch_gate) | (ctrl_q.branch & zero));
  assign ir_write   = ~reset & ctrl_q.ir_write & fetch_gate;
  assign mem_write  = ~reset & ctrl_q.mem_write;
  assign reg_write  = ~reset & ctrl_q.reg_write;
  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign state_dbg  = state;

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed plus randomized bench for multicycle_controller. The reference
//   model expands each opcode into its expected state walk and applies the
//   per-state output table. Two instances share the same inputs: dut uses
//   the default skip-on-illegal behaviour and dut_h halts on illegal.
module tb_multicycle_controller;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // ---------------- clock / reset / inputs ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;

  always #5 clk = ~clk;

  // ---------------- DUT (skip illegal) ----------------
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state_dbg;

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .reg_write(reg_write), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // ---------------- DUT (halt on illegal) ----------------
  logic       h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_illegal_op;
  logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_alu_op, h_imm_src;
  logic [3:0] h_state_dbg;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write),
    .ir_write(h_ir_write), .result_src(h_result_src), .alu_src_a(h_alu_src_a),
    .alu_src_b(h_alu_src_b), .alu_op(h_alu_op), .imm_src(h_imm_src),
    .reg_write(h_reg_write), .illegal_op(h_illegal_op), .state_dbg(h_state_dbg)
  );

  // Control vector: {pc_write, adr_src, mem_write, ir_write, result_src,
  //                  alu_src_a, alu_src_b, alu_op, reg_write}
  logic [12:0] ctrl_act, h_ctrl_act;
  assign ctrl_act   = {pc_write, adr_src, mem_write, ir_write, result_src,
                       alu_src_a, alu_src_b, alu_op, reg_write};
  assign h_ctrl_act = {h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_result_src,
                       h_alu_src_a, h_alu_src_b, h_alu_op, h_reg_write};
  logic [3:0] strobes, h_strobes;
  assign strobes   = {pc_write, ir_write, mem_write, reg_write};
  assign h_strobes = {h_pc_write, h_ir_write, h_mem_write, h_reg_write};

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic       model_illegal;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [6:0] o);
    return (o == 7'd3) || (o == 7'd35) || (o == 7'd51) ||
           (o == 7'd19) || (o == 7'd99) || (o == 7'd111);
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'd35:   return 2'b01;
      7'd99:   return 2'b10;
      7'd111:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Output table indexed by state, with the live zero / mem_ready inputs.
  function automatic logic [12:0] exp_ctrl(input logic [3:0] s, input logic z, input logic mr);
    logic g;
    g = WAIT_EN ? mr : 1'b1;
    case (s)
      4'd0:  return {g, 1'b0, 1'b0, g, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
      4'd1:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
      4'd2:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
      4'd3:  return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd4:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
      4'd5:  return {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd6:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
      4'd7:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
      4'd8:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
      4'd9:  return {z,    1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
      4'd10: return {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
      default: return 13'd0;
    endcase
  endfunction

  // Expected state walk of one instruction, starting at FETCH.
  task automatic build_walk(input logic [6:0] o);
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (o)
      7'd3:    begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      7'd35:   begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      7'd51:   begin exp_q.push_back(4'd6); exp_q.push_back(4'd8); end
      7'd19:   begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); end
      7'd99:   exp_q.push_back(4'd9);
      7'd111:  begin exp_q.push_back(4'd10); exp_q.push_back(4'd8); end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set just after a rising edge; outputs are checked on the
  // falling edge that follows.
  task automatic check_cycle(input logic [3:0] s);
    @(negedge clk);
    check("state", 16'(state_dbg), 16'(s));
    check("ctrl", 16'(ctrl_act), 16'(exp_ctrl(s, zero, mem_ready)));
    check("imm_src", 16'(imm_src), 16'(exp_imm(op)));
    check("illegal_op", 16'(illegal_op), 16'(model_illegal));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; op = 7'd51; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("reset_strobes_pre", 16'(strobes), 16'd0);
    @(posedge clk); #1;
    for (int i = 1; i < cycles; i++) begin
      @(negedge clk);
      check("reset_state", 16'(state_dbg), 16'd0);
      check("reset_strobes", 16'(strobes), 16'd0);
      check("reset_illegal", 16'(illegal_op), 16'd0);
      check("reset_h_state", 16'(h_state_dbg), 16'd0);
      check("reset_h_illegal", 16'(h_illegal_op), 16'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_illegal = 1'b0;
  endtask

  // zero_force: -1 random, else the zero value in BEQ.
  // abort_state: -1 none, else assert reset while in that state.
  // wait_force: -1 random, else wait cycles in MEMREAD/MEMWRITE.
  task automatic run_instr(input logic [6:0] o, input int zero_force,
                           input int abort_state, input int wait_force);
    logic [3:0] s;
    int waits;
    op = o;
    build_walk(o);
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      waits = 0;
      if (WAIT_EN && (s == 4'd0 || s == 4'd3 || s == 4'd5)) begin
        waits = $urandom_range(0, 2);
        if (wait_force >= 0 && s != 4'd0) waits = wait_force;
      end
      for (int w = 0; w < waits; w++) begin
        mem_ready = 1'b0;
        zero = 1'($urandom_range(0, 1));
        check_cycle(s);
      end
      mem_ready = WAIT_EN ? 1'b1 : 1'($urandom_range(0, 1));
      zero = (s == 4'd9 && zero_force >= 0) ? 1'(zero_force) : 1'($urandom_range(0, 1));
      if (int'(s) == abort_state) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", 16'(state_dbg), 16'(s));
        check("abort_strobes", 16'(strobes), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_illegal = 1'b0;
        exp_q.delete();
        break;
      end
      check_cycle(s);
      if (s == 4'd1 && !is_legal(o)) model_illegal = 1'b1;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [6:0] legal_ops[6];
    logic [6:0] rop;
    legal_ops[0] = 7'd3;  legal_ops[1] = 7'd35; legal_ops[2] = 7'd51;
    legal_ops[3] = 7'd19; legal_ops[4] = 7'd99; legal_ops[5] = 7'd111;
    model_illegal = 1'b0;

    do_reset(3);
    run_instr(7'd51, -1, -1, -1);
    run_instr(7'd3, -1, -1, -1);
    run_instr(7'd99, 1, -1, -1);
    run_instr(7'd99, 0, -1, -1);
    run_instr(7'd19, -1, -1, -1);
    run_instr(7'd111, -1, -1, -1);
    run_instr(7'd35, -1, -1, 3);

    // Illegal opcode: dut comes back to FETCH, dut_h parks in HALT.
    run_instr(7'h7F, -1, -1, -1);
    op = 7'd51; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_state", 16'(h_state_dbg), 16'd11);
      check("halt_ctrl", 16'(h_ctrl_act), 16'd0);
      check("halt_illegal", 16'(h_illegal_op), 16'd1);
      check("skip_illegal_sticky", 16'(illegal_op), 16'd1);
      @(posedge clk); #1;
    end
    do_reset(2);

    // Reset during MEMWB aborts the load and suppresses its write.
    run_instr(7'd3, -1, 4, -1);
    run_instr(7'd51, -1, -1, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 7'($urandom_range(0, 127));
        if (is_legal(rop)) rop = 7'h0B;
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(rop, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sequences the shared datapath: PC, instruction register, the single ALU and a unified instruction/data memory port. It decodes the opcode once per instruction and walks it through fetch, decode, execute, memory and writeback states, driving all datapath enables and mux selects. Supported opcodes are lw (3), sw (35), R-type (51), I-type ALU (19), beq (99) and jal (111). ALU function decode stays in the separate ALU decoder, which is driven by `alu_op`.

## Interface
- `ILLEGAL_HALT`, default 0. When 1, an unsupported opcode parks the FSM in HALT until reset. When 0, the instruction is skipped and the FSM returns to FETCH.

- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  opcode field of the instruction register
- `zero`  in  1  ALU zero flag, same-cycle
- `mem_ready`  in  1  memory access complete this cycle (see Configuration)
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  IR/OldPC register enable
- `result_src`  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = const 4
- `alu_op`  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `reg_write`  out  1  register file write enable
- `illegal_op`  out  1  sticky flag: an unsupported opcode has been decoded
- `state_dbg`  out  4  current state encoding, for VGA debug overlay

## Operation
- States and their encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
- Transitions:
  - FETCH → DECODE.
  - DECODE dispatches by opcode: 3 and 35 → MEMADR; 51 → EXECUTER; 19 → EXECUTEI; 99 → BEQ; 111 → JAL; any other opcode → HALT or FETCH per `ILLEGAL_HALT`, and `illegal_op` is set.
  - MEMADR → MEMREAD for opcode 3, MEMWRITE for opcode 35.
  - MEMREAD → MEMWB → FETCH. MEMWRITE → FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - BEQ → FETCH. JAL → ALUWB. HALT → HALT.
- Moore outputs per state. Any field not listed is 0.
  - FETCH: `ir_write`, `pc_write` (PC update); `alu_src_b` = 10; `result_src` = 10.
  - DECODE: `alu_src_a` = 01, `alu_src_b` = 01 (computes branch/jump target into ALUOut).
  - MEMADR: `alu_src_a` = 10, `alu_src_b` = 01.
  - MEMREAD: `adr_src` = 1.
  - MEMWB: `result_src` = 01, `reg_write`.
  - MEMWRITE: `adr_src` = 1, `mem_write`.
  - EXECUTER: `alu_src_a` = 10, `alu_op` = 10.
  - EXECUTEI: `alu_src_a` = 10, `alu_src_b` = 01, `alu_op` = 10.
  - ALUWB: `reg_write`.
  - BEQ: `alu_src_a` = 10, `alu_op` = 01, `pc_write` = `zero`.
  - JAL: `alu_src_a` = 01, `alu_src_b` = 10, `pc_write`.
  - HALT: all outputs 0.
- `imm_src` is combinational from `op` in every state: 3/19 → 00, 35 → 01, 99 → 10, 111 → 11, other → 00.

## Timing
- While `reset` is high, `pc_write`, `ir_write`, `mem_write` and `reg_write` are forced to 0. The first clock edge with `reset` high sets the state to FETCH and clears `illegal_op`.
- On the first cycle after reset deasserts, FETCH outputs are active.
- Reset asserted mid-instruction aborts it. A `mem_write` or `reg_write` in that cycle is suppressed.
- Cycle counts with zero-wait memory: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- `pc_write` in BEQ depends combinationally on `zero`. No register sits between them.
- `illegal_op` sets on the edge that leaves DECODE with an unsupported opcode and stays set until reset.

## Configuration
- Macro: `MC_MEM_WAIT_EN`.
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready` = 0. They advance on the edge where `mem_ready` = 1.
  - In FETCH, `ir_write` and `pc_write` are asserted only when `mem_ready` = 1.
  - `mem_write` stays asserted for the whole MEMWRITE dwell.
- Undefined:
  - `mem_ready` is ignored and every state lasts exactly one cycle.

## Test plan
- Reset held 3 cycles, then released with op = 51 → `state_dbg` sequence 0,1,6,8,0. `reg_write` high only in state 8. `alu_op` = 10 in state 6.
- op = 3 → states 0,1,2,3,4,0. `adr_src` = 1 in state 3. `result_src` = 01 and `reg_write` = 1 in state 4. `imm_src` = 00.
- op = 99 run twice, once with `zero` = 1 and once with `zero` = 0 in BEQ → `pc_write` = 1 and 0 respectively. 3-cycle instruction. `imm_src` = 10.
- op = 7'h7F → `illegal_op` rises after DECODE. With `ILLEGAL_HALT` = 0 the FSM returns to FETCH. With 1 it holds `state_dbg` = 11 with all outputs 0 until reset.
- `MC_MEM_WAIT_EN` defined, op = 35, `mem_ready` low for 3 cycles in MEMWRITE → `mem_write` high for 4 cycles, then FETCH.
- Reset asserted during MEMWB → `reg_write` = 0 that cycle. State is FETCH after the edge.
